// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: serial line and received-byte bundle for uart_rx_os.
// Optional perr signal is present when UART_RX_PARITY_EN is defined.
interface uart_rx_os_if;
  logic       rx;
  logic [7:0] doutrx;
  logic       donerx;
  logic       ferr;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       perr;
`endif

  modport master (
    input  rx,
`ifdef UART_RX_PARITY_EN
    output perr,
`endif
    output doutrx, donerx, ferr, busy
  );

  modport slave (
    output rx,
`ifdef UART_RX_PARITY_EN
    input  perr,
`endif
    input  doutrx, donerx, ferr, busy
  );
endinterface

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampling 8N1 UART receiver, mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit and the perr pulse.
module uart_rx_os #(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600,
  parameter int OVS       = 16
) (
  input logic clk,
  input logic rst,
  uart_rx_os_if.master bus
);

  localparam int DIV = clk_freq / (baud_rate * OVS);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SCW = $clog2(OVS);

  localparam logic [PW-1:0]  PC_END = PW'(DIV - 1);
  localparam logic [SCW-1:0] SC_MID = SCW'(OVS / 2 - 1);
  localparam logic [SCW-1:0] SC_END = SCW'(OVS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t state, state_n;

  logic           r1, rs, prev;
  logic [PW-1:0]  pc, pc_n;
  logic [SCW-1:0] sc, sc_n;
  logic [2:0]     bc, bc_n;
  logic [7:0]     sh, sh_n;
  logic [7:0]     dout, dout_n;
  logic           done, done_n;
  logic           fe, fe_n;
  logic           tick;
`ifdef UART_RX_PARITY_EN
  logic           par, par_n;
  logic           pe, pe_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r1   <= 1'b1;
      rs   <= 1'b1;
      prev <= 1'b1;
    end else begin
      r1   <= bus.rx;
      rs   <= r1;
      prev <= rs;
    end
  end

  assign tick = (pc == PC_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      sc    <= '0;
      bc    <= '0;
      sh    <= '0;
      dout  <= '0;
      done  <= 1'b0;
      fe    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par   <= 1'b0;
      pe    <= 1'b0;
`endif
    end else begin
      state <= state_n;
      pc    <= pc_n;
      sc    <= sc_n;
      bc    <= bc_n;
      sh    <= sh_n;
      dout  <= dout_n;
      done  <= done_n;
      fe    <= fe_n;
`ifdef UART_RX_PARITY_EN
      par   <= par_n;
      pe    <= pe_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = tick ? '0 : pc + 1'b1;
    sc_n    = sc;
    bc_n    = bc;
    sh_n    = sh;
    dout_n  = dout;
    done_n  = 1'b0;
    fe_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n   = par;
    pe_n    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        // Holding the prescaler at 0 aligns ticks to the start edge
        pc_n = '0;
        sc_n = '0;
        bc_n = '0;
        if (prev && !rs) state_n = START;
      end
      START: begin
        if (tick) begin
          if (sc == SC_MID) begin
            sc_n = '0;
            bc_n = '0;
            state_n = rs ? IDLE : DATA;
          end else begin
            sc_n = sc + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (sc == SC_END) begin
            sh_n = {rs, sh[7:1]};
            sc_n = '0;
            bc_n = bc + 1'b1;
            if (bc == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end
          end else begin
            sc_n = sc + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (sc == SC_END) begin
            par_n   = rs ^ (^sh);
            sc_n    = '0;
            state_n = STOP;
          end else begin
            sc_n = sc + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (sc == SC_END) begin
            if (rs) begin
              dout_n = sh;
              done_n = 1'b1;
            end else begin
              fe_n = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            pe_n = par;
`endif
            sc_n    = '0;
            state_n = IDLE;
          end else begin
            sc_n = sc + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.doutrx = dout;
  assign bus.donerx = done;
  assign bus.ferr   = fe;
  assign bus.busy   = (state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.perr   = pe;
`endif

endmodule
